backlight_fade_ctrl: RTL and testbench
======================================

// Module: backlight_fade_ctrl
// PURPOSE
//  Sequences the LCD backlight: PWM brightness with timed fade-up, dim and fade-off stages.
//  Idle timeout dims the panel, then turns it off. A touch restores full brightness.
//  Sits between the touch controller and the backlight driver pin, replacing a hard on/off enable.
// PARAMETERS
//  PWM_BITS          8          width of brightness level and PWM counter; full = 2**PWM_BITS-1
//  FADE_STEP_CYCLES  65536      clocks per 1-LSB brightness step during any fade (>=1)
//  IDLE_DIM_CYCLES   2**32      idle clocks (no touch) before dimming starts (>=1)
//  IDLE_OFF_CYCLES   2**33      idle clocks before fade-off starts; must be > IDLE_DIM_CYCLES
//  DIM_LEVEL         32         brightness held in DIM; 0 < DIM_LEVEL < full
// PORTS
//  i_Clk      in   1         system clock
//  i_Reset    in   1         asynchronous, active-high reset
//  i_Touch    in   1         touch activity, level; high = user active
//  o_Light    out  1         registered PWM drive to backlight
//  o_Level    out  PWM_BITS  current brightness level
//  o_Awake    out  1         1 in every state except OFF
// BEHAVIOUR
//  - Reset (async, active-high): state=FADE_UP, o_Level=0, PWM ctr=0, idle ctr=0, step timer=0,
//    o_Light=0, o_Awake=1. Release: fade-up starts on the first clock edge after reset deasserts.
//  - PWM: ctr free-runs 0..full, wraps to 0. o_Light <= (ctr < o_Level); 1 clk latency.
//    Level 0 -> o_Light constant 0; level full -> high full of every 2**PWM_BITS clocks.
//  - Idle ctr: cleared while touch (as seen by FSM) is high, else +1. Saturates at IDLE_OFF_CYCLES.
//  - Step timer: counts 0..FADE_STEP_CYCLES-1. o_Level moves 1 LSB toward target on the clock the
//    timer is at FADE_STEP_CYCLES-1. Timer clears on every state change and in ON/DIM/OFF.
//  - States (target level):
//    OFF(0), FADE_UP(full), ON(full), DIMMING(DIM_LEVEL), DIM(DIM_LEVEL), FADE_OFF(0).
//  - Transitions (touch has priority over all others):
//    any state, touch=1        -> FADE_UP (from ON: stays ON; level does not drop)
//    FADE_UP, level==full      -> ON
//    ON, idle>=IDLE_DIM_CYCLES -> DIMMING
//    DIMMING, level==DIM_LEVEL -> DIM (DIMMING always starts above DIM_LEVEL)
//    DIM, idle>=IDLE_OFF_CYCLES -> FADE_OFF
//    FADE_OFF, level==0        -> OFF
//  - Touch mid-fade: direction reverses from the current level. No jump; step timer restarts.
//  - Touch held: idle ctr stays 0, state stays FADE_UP/ON; no dimming.
//  - o_Level never under/overflows. Increments stop at full; decrements stop at target.
//  - Reset asserted mid-fade: immediate return to reset values; no partial-step carry over.
// CONFIGURATION
//  BACKLIGHT_TOUCH_SYNC_EN defined: i_Touch passes a 2-flop synchronizer (reset to 0) before
//    FSM and idle ctr. This adds 2 clocks of touch-to-response latency.
//  Undefined: i_Touch is used directly. i_Touch must then be synchronous to i_Clk.
//  The test plan latencies assume the macro is undefined.
// TESTING  (PWM_BITS=4, FADE_STEP_CYCLES=2, IDLE_DIM_CYCLES=100, IDLE_OFF_CYCLES=200, DIM_LEVEL=4)
//  1 reset, touch=0 -> level 0 at reset, +1 every 2 clks, reaches 15 at clk 30, state ON, o_Awake=1
//  2 no touch, no further stimulus -> DIMMING at idle 100, level 15->4 in 22 clks, DIM;
//    FADE_OFF at idle 200, level reaches 0 after 8 clks, OFF, o_Awake=0, o_Light stuck 0
//  3 in OFF, 1-clk touch pulse -> FADE_UP next clk, o_Awake=1, level 0->15 in 30 clks
//  4 touch during DIMMING at level 9 -> FADE_UP; level 10 after 2 clks, no step below 9
//  5 level=4 steady -> o_Light high exactly 4 of every 16 clks; level 15 -> high 15 of 16
//  6 reset asserted mid-FADE_OFF at level 2 -> o_Level=0, o_Light=0, state FADE_UP without clock edge

Source files
------------

// File: rtl/backlight_fade_ctrl.sv
// backlight_fade_ctrl: LCD backlight sequencer. The brightness level fades up
// to full, dims after an idle timeout, fades off after a longer timeout, and a
// touch restores full brightness. The level drives a registered PWM output.
// Optional macro BACKLIGHT_TOUCH_SYNC_EN: when defined, i_Touch passes a
// 2-flop synchronizer before use. This adds 2 clocks of touch-to-response latency.
module backlight_fade_ctrl #(
  parameter int unsigned     PWM_BITS         = 8,
  parameter int unsigned     FADE_STEP_CYCLES = 65536,
  parameter longint unsigned IDLE_DIM_CYCLES  = 64'h1_0000_0000,
  parameter longint unsigned IDLE_OFF_CYCLES  = 64'h2_0000_0000,
  parameter int unsigned     DIM_LEVEL        = 32
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  input  logic                i_Touch,
  output logic                o_Light,
  output logic [PWM_BITS-1:0] o_Level,
  output logic                o_Awake
);

  localparam int unsigned STEP_W = (FADE_STEP_CYCLES > 1) ? $clog2(FADE_STEP_CYCLES) : 1;
  localparam int unsigned IDLE_W = $clog2(IDLE_OFF_CYCLES + 1);

  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(FADE_STEP_CYCLES - 1);
  localparam logic [IDLE_W-1:0]   IDLE_DIM  = IDLE_W'(IDLE_DIM_CYCLES);
  localparam logic [IDLE_W-1:0]   IDLE_OFF  = IDLE_W'(IDLE_OFF_CYCLES);
  localparam logic [PWM_BITS-1:0] FULL      = '1;
  localparam logic [PWM_BITS-1:0] DIM_LVL   = PWM_BITS'(DIM_LEVEL);

  typedef enum logic [2:0] {
    S_OFF,
    S_FADE_UP,
    S_ON,
    S_DIMMING,
    S_DIM,
    S_FADE_OFF
  } state_t;

  state_t              state, state_nxt;
  logic                touch;
  logic [IDLE_W-1:0]   idle_ctr;
  logic [STEP_W-1:0]   step_tmr, step_tmr_nxt;
  logic [PWM_BITS-1:0] pwm_ctr;
  logic [PWM_BITS-1:0] target;
  logic [PWM_BITS-1:0] level_nxt;
  logic                fading;
  logic                step_en;

`ifdef BACKLIGHT_TOUCH_SYNC_EN
  logic [1:0] touch_sync;

  // Two-flop synchronizer for an asynchronous touch source.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) touch_sync <= '0;
    else         touch_sync <= {touch_sync[0], i_Touch};
  end

  assign touch = touch_sync[1];
`else
  assign touch = i_Touch;
`endif

  // Idle counter: cleared by touch activity, otherwise counts up and saturates.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset)               idle_ctr <= '0;
    else if (touch)            idle_ctr <= '0;
    else if (idle_ctr != IDLE_OFF) idle_ctr <= idle_ctr + IDLE_W'(1);
  end

  // State, brightness level and fade step timer registers.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state    <= S_FADE_UP;
      o_Level  <= '0;
      step_tmr <= '0;
    end else begin
      state    <= state_nxt;
      o_Level  <= level_nxt;
      step_tmr <= step_tmr_nxt;
    end
  end

  // Next-state, per-state target level and fade stepping.
  // A step is suppressed on the edge where the state changes, so a touch
  // mid-fade reverses from the current level without a stray step.
  always_comb begin
    state_nxt    = state;
    target       = '0;
    fading       = 1'b0;
    step_en      = 1'b0;
    level_nxt    = o_Level;
    step_tmr_nxt = '0;

    case (state)
      S_OFF:      target = '0;
      S_FADE_UP:  begin target = FULL;    fading = 1'b1; end
      S_ON:       target = FULL;
      S_DIMMING:  begin target = DIM_LVL; fading = 1'b1; end
      S_DIM:      target = DIM_LVL;
      S_FADE_OFF: begin target = '0;      fading = 1'b1; end
      default:    target = '0;
    endcase

    if (touch) begin
      state_nxt = (state == S_ON) ? S_ON : S_FADE_UP;
    end else begin
      case (state)
        S_FADE_UP:  if (o_Level == FULL)    state_nxt = S_ON;
        S_ON:       if (idle_ctr >= IDLE_DIM) state_nxt = S_DIMMING;
        S_DIMMING:  if (o_Level == DIM_LVL) state_nxt = S_DIM;
        S_DIM:      if (idle_ctr >= IDLE_OFF) state_nxt = S_FADE_OFF;
        S_FADE_OFF: if (o_Level == '0)      state_nxt = S_OFF;
        S_OFF:      state_nxt = S_OFF;
        default:    state_nxt = S_FADE_UP;
      endcase
    end

    if (fading && (state_nxt == state) && (step_tmr != STEP_LAST))
      step_tmr_nxt = step_tmr + STEP_W'(1);

    step_en = fading && (state_nxt == state) && (step_tmr == STEP_LAST);

    if (step_en) begin
      if (o_Level < target)      level_nxt = o_Level + PWM_BITS'(1);
      else if (o_Level > target) level_nxt = o_Level - PWM_BITS'(1);
    end
  end

  // Free-running PWM counter and registered compare output.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      pwm_ctr <= '0;
      o_Light <= 1'b0;
    end else begin
      pwm_ctr <= pwm_ctr + PWM_BITS'(1);
      o_Light <= (pwm_ctr < o_Level);
    end
  end

  assign o_Awake = (state != S_OFF);

endmodule

// File: tb/tb_backlight_fade_ctrl.sv
// Directed bench for backlight_fade_ctrl with small timing parameters.
module tb_backlight_fade_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       touch;
  logic       light;
  logic [3:0] level;
  logic       awake;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned t     = 0;

  always #5 clk = ~clk;

  backlight_fade_ctrl #(
    .PWM_BITS         (4),
    .FADE_STEP_CYCLES (2),
    .IDLE_DIM_CYCLES  (100),
    .IDLE_OFF_CYCLES  (200),
    .DIM_LEVEL        (4)
  ) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .i_Touch (touch),
    .o_Light (light),
    .o_Level (level),
    .o_Awake (awake)
  );

  typedef struct {
    int unsigned adv;
    logic        touch;
    logic [3:0]  level;
    logic        awake;
    logic        pwm;
    int unsigned pwm_hi;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int unsigned adv, input logic tch, input logic [3:0] lv,
                     input logic aw, input logic pw, input int unsigned hi);
    vec_t v;
    v.adv = adv; v.touch = tch; v.level = lv; v.awake = aw; v.pwm = pw; v.pwm_hi = hi;
    tbl.push_back(v);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
      t++;
    end
  endtask

  task automatic chk_lvl(input string nm, input logic [3:0] exp);
    n_vec++;
    if (level !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d level got %0d want %0d", nm, t, level, exp);
    end
  endtask

  task automatic chk_bit(input string nm, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got %b want %b", nm, t, got, exp);
    end
  endtask

  task automatic pwm_window(output int unsigned hi);
    hi = 0;
    repeat (16) begin
      tick(1);
      if (light === 1'b1) hi++;
    end
  endtask

  initial begin
    int unsigned hi;

    // t = edge count after reset release; comments give t after each entry.
    add(1,  1'b0, 4'd0,  1'b1, 1'b0, 0);   // 1
    add(1,  1'b0, 4'd1,  1'b1, 1'b0, 0);   // 2
    add(1,  1'b0, 4'd1,  1'b1, 1'b0, 0);   // 3
    add(1,  1'b0, 4'd2,  1'b1, 1'b0, 0);   // 4
    add(25, 1'b0, 4'd14, 1'b1, 1'b0, 0);   // 29
    add(1,  1'b0, 4'd15, 1'b1, 1'b0, 0);   // 30
    add(10, 1'b0, 4'd15, 1'b1, 1'b1, 15);  // 40, window to 56
    add(44, 1'b0, 4'd15, 1'b1, 1'b0, 0);   // 100
    add(1,  1'b0, 4'd15, 1'b1, 1'b0, 0);   // 101 enter DIMMING
    add(1,  1'b0, 4'd15, 1'b1, 1'b0, 0);   // 102
    add(1,  1'b0, 4'd14, 1'b1, 1'b0, 0);   // 103
    add(8,  1'b0, 4'd10, 1'b1, 1'b0, 0);   // 111
    add(12, 1'b0, 4'd4,  1'b1, 1'b0, 0);   // 123
    add(1,  1'b0, 4'd4,  1'b1, 1'b0, 0);   // 124 DIM
    add(6,  1'b0, 4'd4,  1'b1, 1'b1, 4);   // 130, window to 146
    add(54, 1'b0, 4'd4,  1'b1, 1'b0, 0);   // 200
    add(1,  1'b0, 4'd4,  1'b1, 1'b0, 0);   // 201 enter FADE_OFF
    add(2,  1'b0, 4'd3,  1'b1, 1'b0, 0);   // 203
    add(6,  1'b0, 4'd0,  1'b1, 1'b0, 0);   // 209
    add(1,  1'b0, 4'd0,  1'b0, 1'b1, 0);   // 210 OFF, window to 226
    add(1,  1'b1, 4'd0,  1'b1, 1'b0, 0);   // 227 touch pulse -> FADE_UP
    add(2,  1'b0, 4'd1,  1'b1, 1'b0, 0);   // 229
    add(28, 1'b0, 4'd15, 1'b1, 1'b0, 0);   // 257
    add(83, 1'b0, 4'd9,  1'b1, 1'b0, 0);   // 340 DIMMING at level 9

    rst   = 1'b1;
    touch = 1'b0;
    #12;
    chk_lvl("reset_level", 4'd0);
    chk_bit("reset_light", light, 1'b0);
    chk_bit("reset_awake", awake, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    t   = 0;

    for (int i = 0; i < tbl.size(); i++) begin
      touch = tbl[i].touch;
      tick(tbl[i].adv);
      chk_lvl($sformatf("vec%0d_level", i), tbl[i].level);
      chk_bit($sformatf("vec%0d_awake", i), awake, tbl[i].awake);
      if (tbl[i].pwm) begin
        pwm_window(hi);
        n_vec++;
        if (hi != tbl[i].pwm_hi) begin
          n_bad++;
          $display("FAIL vec%0d_pwm t=%0d high count got %0d want %0d", i, t, hi, tbl[i].pwm_hi);
        end
      end
    end

    // Touch on the edge where DIMMING would step 9 -> 8: reverse without stepping.
    touch = 1'b0;
    tick(1);                                 // 341
    chk_lvl("rev_pre", 4'd9);
    touch = 1'b1;
    tick(1);                                 // 342
    chk_lvl("rev_touch_edge", 4'd9);
    chk_bit("rev_awake", awake, 1'b1);
    touch = 1'b0;
    tick(1);                                 // 343
    chk_lvl("rev_plus1", 4'd9);
    tick(1);                                 // 344
    chk_lvl("rev_plus2", 4'd10);
    tick(10);                                // 354
    chk_lvl("rev_full", 4'd15);

    // Run to FADE_OFF at level 2, then assert reset between clock edges.
    tick(191);                               // 545
    chk_lvl("fo_lvl3", 4'd3);
    tick(2);                                 // 547
    chk_lvl("fo_lvl2", 4'd2);
    #2;
    rst = 1'b1;
    #1;
    chk_lvl("async_rst_level", 4'd0);
    chk_bit("async_rst_light", light, 1'b0);
    chk_bit("async_rst_awake", awake, 1'b1);
    #1;
    rst = 1'b0;
    tick(1);
    chk_lvl("post_rst_1", 4'd0);
    tick(1);
    chk_lvl("post_rst_2", 4'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
